// File: rtl/clint_timer_sequencer.sv
// Programs the CLINT MTIMECMP register to MTIME + period over a simple bus master port.
// Reads MTIME tear-free, performs the glitch-safe three-write update, and optionally re-arms on each timer interrupt.
module clint_timer_sequencer #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter int          TIMEOUT    = 16,
    parameter int          MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic        cfg_periodic,
    input  logic [31:0] cfg_period,
    input  logic        start_i,
    input  logic        timer_irq_i,
    output logic        m_bus_en,
    output logic        m_bus_we,
    output logic [31:0] m_bus_addr,
    output logic [31:0] m_bus_wdata,
    input  logic [31:0] m_bus_rdata,
    input  logic        m_bus_ready,
    output logic        busy_o,
    output logic        done_o,
    output logic        tick_o,
    output logic        err_o
);
    localparam logic [31:0] MTIMECMP_LO = CLINT_BASE + 32'h0000_4000;
    localparam logic [31:0] MTIMECMP_HI = CLINT_BASE + 32'h0000_4004;
    localparam logic [31:0] MTIME_LO    = CLINT_BASE + 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI    = CLINT_BASE + 32'h0000_BFFC;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_HI1, ST_RD_LO, ST_RD_HI2, ST_WR_LO0, ST_WR_HI, ST_WR_LO1, ST_DONE
    } state_t;

    state_t        state_reg;
    logic          en_reg, we_reg, done_reg, tick_reg, err_reg;
    logic [31:0]   addr_reg, wdata_reg;
    logic          pending_reg, irq_seen_reg;
    logic [RW-1:0] retry_reg;
    logic [TW-1:0] tmo_reg;
    logic [31:0]   h1_reg, lo_reg, period_reg;
    logic [63:0]   target_reg;

    logic          host_trig, periodic_trig;
    logic [31:0]   addr_next, wdata_next;
    logic          we_next;

    assign host_trig     = start_i || pending_reg;
    assign periodic_trig = cfg_periodic && timer_irq_i && !irq_seen_reg;

    // Address/data of the transaction belonging to the current bus state.
    always_comb begin
        addr_next  = MTIME_HI;
        we_next    = 1'b0;
        wdata_next = 32'h0;
        case (state_reg)
            ST_RD_LO:  addr_next = MTIME_LO;
            ST_WR_LO0: begin addr_next = MTIMECMP_LO; we_next = 1'b1; wdata_next = 32'hFFFF_FFFF; end
            ST_WR_HI:  begin addr_next = MTIMECMP_HI; we_next = 1'b1; wdata_next = target_reg[63:32]; end
            ST_WR_LO1: begin addr_next = MTIMECMP_LO; we_next = 1'b1; wdata_next = target_reg[31:0]; end
            default:   addr_next = MTIME_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            en_reg       <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            done_reg     <= 1'b0;
            tick_reg     <= 1'b0;
            err_reg      <= 1'b0;
            pending_reg  <= 1'b0;
            irq_seen_reg <= 1'b0;
            retry_reg    <= '0;
            tmo_reg      <= '0;
            h1_reg       <= 32'h0;
            lo_reg       <= 32'h0;
            period_reg   <= 32'h0;
            target_reg   <= 64'h0;
        end else begin
            done_reg <= 1'b0;
            tick_reg <= 1'b0;
            if (!timer_irq_i)
                irq_seen_reg <= 1'b0;
            if (start_i && state_reg != ST_IDLE)
                pending_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (cfg_enable && (host_trig || periodic_trig)) begin
                        state_reg   <= ST_RD_HI1;
                        period_reg  <= (cfg_period == 32'h0) ? 32'h1 : cfg_period;
                        retry_reg   <= '0;
                        pending_reg <= 1'b0;
                        if (host_trig)
                            err_reg <= 1'b0;
                        if (periodic_trig) begin
                            tick_reg     <= 1'b1;
                            irq_seen_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: begin
                    // Entering a bus state with en low gives the mandatory one-cycle gap.
                    if (!en_reg) begin
                        en_reg    <= 1'b1;
                        we_reg    <= we_next;
                        addr_reg  <= addr_next;
                        wdata_reg <= wdata_next;
                        tmo_reg   <= '0;
                    end else if (m_bus_ready) begin
                        en_reg <= 1'b0;
                        case (state_reg)
                            ST_RD_HI1: begin h1_reg <= m_bus_rdata; state_reg <= ST_RD_LO; end
                            ST_RD_LO:  begin lo_reg <= m_bus_rdata; state_reg <= ST_RD_HI2; end
                            ST_RD_HI2: begin
                                if (m_bus_rdata != h1_reg) begin
                                    if (retry_reg == RETRY_MAX) begin
                                        err_reg   <= 1'b1;
                                        state_reg <= ST_IDLE;
                                    end else begin
                                        retry_reg <= retry_reg + 1'b1;
                                        state_reg <= ST_RD_HI1;
                                    end
                                end else begin
                                    target_reg <= {h1_reg, lo_reg} + {32'h0, period_reg};
                                    state_reg  <= ST_WR_LO0;
                                end
                            end
                            ST_WR_LO0: state_reg <= ST_WR_HI;
                            ST_WR_HI:  state_reg <= ST_WR_LO1;
                            default: begin
                                done_reg  <= 1'b1;
                                state_reg <= ST_DONE;
                            end
                        endcase
                    end else if (tmo_reg == TMO_LAST) begin
                        en_reg      <= 1'b0;
                        err_reg     <= 1'b1;
                        pending_reg <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign m_bus_en    = en_reg;
    assign m_bus_we    = we_reg;
    assign m_bus_addr  = addr_reg;
    assign m_bus_wdata = wdata_reg;
    assign busy_o      = (state_reg != ST_IDLE);
    assign done_o      = done_reg;
    assign tick_o      = tick_reg;
    assign err_o       = err_reg;
endmodule

// File: tb/tb_clint_timer_sequencer.sv
// Bench for clint_timer_sequencer: CLINT bus stub plus a transaction-level model of the expected bus traffic.
module tb_clint_timer_sequencer;
    localparam logic [31:0] CMP_LO = 32'h0200_4000;
    localparam logic [31:0] CMP_HI = 32'h0200_4004;
    localparam logic [31:0] MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] MT_HI  = 32'h0200_BFFC;

    logic        clk, rst, cfg_enable, cfg_periodic, start_i, timer_irq_i;
    logic [31:0] cfg_period;
    logic        m_bus_en, m_bus_we, m_bus_ready;
    logic [31:0] m_bus_addr, m_bus_wdata, m_bus_rdata;
    logic        busy_o, done_o, tick_o, err_o;

    clint_timer_sequencer dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_periodic(cfg_periodic),
        .cfg_period(cfg_period), .start_i(start_i), .timer_irq_i(timer_irq_i),
        .m_bus_en(m_bus_en), .m_bus_we(m_bus_we), .m_bus_addr(m_bus_addr),
        .m_bus_wdata(m_bus_wdata), .m_bus_rdata(m_bus_rdata), .m_bus_ready(m_bus_ready),
        .busy_o(busy_o), .done_o(done_o), .tick_o(tick_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] hi_q[$];
    logic [63:0] mtime;
    logic [31:0] last_hi, last_lo;
    int          total = 0, bad = 0;
    int          done_cnt = 0, tick_cnt = 0, en_cycles = 0;
    int          lat = 0, wcnt = 0;
    logic        never_ready = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [31:0] a, input logic w, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.we = w; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic exp_reads();
        push_txn(MT_HI, 1'b0, 32'h0);
        push_txn(MT_LO, 1'b0, 32'h0);
        push_txn(MT_HI, 1'b0, 32'h0);
    endtask

    // One full arming sequence: tear-free read, then the three-write compare update.
    task automatic exp_seq(input logic [63:0] mt, input logic [31:0] p);
        logic [63:0] tgt;
        tgt = mt + ((p == 32'h0) ? 64'd1 : {32'h0, p});
        exp_reads();
        push_txn(CMP_LO, 1'b1, 32'hFFFF_FFFF);
        push_txn(CMP_HI, 1'b1, tgt[63:32]);
        push_txn(CMP_LO, 1'b1, tgt[31:0]);
    endtask

    // CLINT stub and per-transaction compare process.
    always @(negedge clk) begin
        txn_t e;
        if (done_o) done_cnt++;
        if (tick_o) tick_cnt++;
        if (m_bus_en) en_cycles++;
        if (rst) begin
            m_bus_ready = 1'b0;
            wcnt = 0;
        end else if (m_bus_ready) begin
            m_bus_ready = 1'b0;
            wcnt = 0;
        end else if (m_bus_en && !never_ready) begin
            if (wcnt >= lat) begin
                m_bus_ready = 1'b1;
                if (m_bus_addr == MT_HI)
                    m_bus_rdata = (hi_q.size() > 0) ? hi_q.pop_front() : mtime[63:32];
                else if (m_bus_addr == MT_LO)
                    m_bus_rdata = mtime[31:0];
                else
                    m_bus_rdata = 32'h0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_txn: got addr=%h we=%0b wdata=%h expected none",
                             m_bus_addr, m_bus_we, m_bus_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_addr", 64'(m_bus_addr), 64'(e.addr));
                    chk("txn_we", 64'(m_bus_we), 64'(e.we));
                    chk("txn_busy", 64'(busy_o), 64'd1);
                    if (e.we) begin
                        chk("txn_wdata", 64'(m_bus_wdata), 64'(e.wdata));
                        if (m_bus_addr == CMP_HI) last_hi = m_bus_wdata;
                        else last_lo = m_bus_wdata;
                    end
                end
                $display("txn addr=%h we=%0b wdata=%h rdata=%h", m_bus_addr, m_bus_we,
                         m_bus_wdata, m_bus_rdata);
            end else begin
                wcnt++;
            end
        end else if (!m_bus_en) begin
            wcnt = 0;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int target;
        target = done_cnt + n;
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL %s_timeout: done pulses=%0d expected=%0d", name, done_cnt, target);
        end
    endtask

    task automatic run_seq(input string name);
        int d0;
        d0 = done_cnt;
        pulse_start();
        wait_done(1, 300, name);
        repeat (4) @(negedge clk);
        chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_busy_after"}, 64'(busy_o), 64'd0);
        chk({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0, t0, e0;
        rst = 1'b1; cfg_enable = 1'b1; cfg_periodic = 1'b0; cfg_period = 32'h10;
        start_i = 1'b0; timer_irq_i = 1'b0; m_bus_ready = 1'b0; m_bus_rdata = 32'h0;
        mtime = 64'h100; last_hi = 32'h0; last_lo = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_en", 64'(m_bus_en), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_tick", 64'(tick_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic arm: MTIME 0x100 + 0x10
        exp_seq(64'h100, 32'h10);
        run_seq("basic");
        chk("basic_hi", 64'(last_hi), 64'h0);
        chk("basic_lo", 64'(last_lo), 64'h110);

        // High word changes between reads: one retry pass
        lat = 1; mtime = {32'h1, 32'h5}; hi_q.push_back(32'h0);
        exp_reads();
        exp_seq(mtime, 32'h10);
        run_seq("rollover");
        chk("rollover_hi", 64'(last_hi), 64'h1);
        chk("rollover_lo", 64'(last_lo), 64'h15);

        // Carry into the high word, then period 0 behaving as 1
        lat = 0; mtime = 64'hFFFF_FFF8;
        exp_seq(mtime, 32'h10);
        run_seq("carry");
        chk("carry_hi", 64'(last_hi), 64'h1);
        chk("carry_lo", 64'(last_lo), 64'h8);
        cfg_period = 32'h0;
        exp_seq(mtime, 32'h0);
        run_seq("period0");
        chk("period0_hi", 64'(last_hi), 64'h0);
        chk("period0_lo", 64'(last_lo), 64'hFFFF_FFF9);

        // Disabled: start_i ignored
        cfg_enable = 1'b0; e0 = en_cycles;
        pulse_start();
        repeat (10) @(negedge clk);
        chk("disabled_busy", 64'(busy_o), 64'd0);
        chk("disabled_bus", 64'(en_cycles - e0), 64'd0);
        cfg_enable = 1'b1;

        // Periodic: held interrupt gives one tick, a new edge gives another
        cfg_period = 32'h100; mtime = 64'h2000; cfg_periodic = 1'b1;
        d0 = done_cnt; t0 = tick_cnt;
        exp_seq(mtime, 32'h100);
        exp_seq(mtime, 32'h100);
        @(negedge clk) timer_irq_i = 1'b1;
        repeat (40) @(negedge clk);
        timer_irq_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("periodic_ticks1", 64'(tick_cnt - t0), 64'd1);
        chk("periodic_dones1", 64'(done_cnt - d0), 64'd1);
        timer_irq_i = 1'b1;
        repeat (30) @(negedge clk);
        timer_irq_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("periodic_ticks2", 64'(tick_cnt - t0), 64'd2);
        chk("periodic_dones2", 64'(done_cnt - d0), 64'd2);
        chk("periodic_hi", 64'(last_hi), 64'h0);
        chk("periodic_lo", 64'(last_lo), 64'h2100);
        cfg_periodic = 1'b0;

        // Bus timeout: en held for 16 cycles, then error
        never_ready = 1'b1; e0 = en_cycles;
        pulse_start();
        for (int i = 0; i < 10 && !m_bus_en; i++) @(negedge clk);
        for (int i = 0; i < 40 && m_bus_en; i++) @(negedge clk);
        chk("tmo_en_cycles", 64'(en_cycles - e0), 64'd16);
        chk("tmo_err", 64'(err_o), 64'd1);
        chk("tmo_busy", 64'(busy_o), 64'd0);
        never_ready = 1'b0; cfg_period = 32'h10; mtime = 64'h100;
        exp_seq(mtime, 32'h10);
        pulse_start();
        chk("tmo_err_cleared", 64'(err_o), 64'd0);
        wait_done(1, 300, "after_tmo");
        repeat (4) @(negedge clk);

        // start_i during WR_HI collapses into one follow-up sequence
        mtime = {32'h1234_5678, 32'h9ABC_DEF0}; cfg_period = 32'h20; d0 = done_cnt;
        exp_seq(mtime, 32'h20);
        exp_seq(mtime, 32'h20);
        pulse_start();
        for (int i = 0; i < 40 && !(m_bus_en && m_bus_addr == CMP_HI); i++) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        wait_done(2, 300, "pending");
        repeat (4) @(negedge clk);
        chk("pending_dones", 64'(done_cnt - d0), 64'd2);
        chk("pending_exp_left", 64'(exp_q.size()), 64'd0);
        chk("pending_lo", 64'(last_lo), 64'h9ABC_DF10);

        // Reset while the low MTIME read is outstanding
        lat = 3;
        exp_seq(mtime, 32'h20);
        pulse_start();
        for (int i = 0; i < 40 && !(m_bus_en && m_bus_addr == MT_LO); i++) @(negedge clk);
        chk("rst_mid_seen_rdlo", 64'(m_bus_addr), 64'(MT_LO));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_en", 64'(m_bus_en), 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        chk("rst_mid_done", 64'(done_o), 64'd0);
        chk("rst_mid_err", 64'(err_o), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        hi_q.delete();
        repeat (5) @(negedge clk);
        chk("rst_mid_idle_en", 64'(m_bus_en), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clint_timer_sequencer.md
Name: clint_timer_sequencer

Overview:
- Bus-master controller that programs the CLINT machine timer on behalf of software or a periodic tick service.
- Reads 64-bit MTIME tear-free, adds a programmed period, and writes MTIMECMP with the glitch-safe three-write sequence.
- In periodic mode it re-arms automatically on each timer interrupt.
- Sits between the CLINT slave bus port and the system timer-service logic.

Parameters:
- CLINT_BASE, 32'h0200_0000, CLINT base address. MTIMECMP_LO = BASE+0x4000, MTIMECMP_HI = BASE+0x4004, MTIME_LO = BASE+0xBFF8, MTIME_HI = BASE+0xBFFC.
- TIMEOUT, 16, maximum cycles to wait for bus_ready per transaction.
- MAX_RETRY, 3, maximum MTIME re-read attempts on high-word mismatch.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  sequencer enable.
- cfg_periodic  in  1  1 = automatically re-arm on timer_irq_i.
- cfg_period  in  32  compare offset in mtime ticks; 0 is treated as 1.
- start_i  in  1  one-cycle arm request.
- timer_irq_i  in  1  CLINT timer_irq_o.
- m_bus_en  out  1  bus request.
- m_bus_we  out  1  write strobe.
- m_bus_addr  out  32  address.
- m_bus_wdata  out  32  write data.
- m_bus_rdata  in  32  read data, valid when m_bus_ready=1.
- m_bus_ready  in  1  transaction complete.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse when MTIMECMP write sequence completes.
- tick_o  out  1  one-cycle pulse when a periodic re-arm is triggered.
- err_o  out  1  sticky bus timeout or retry exhaustion.

Behaviour:
- Reset: all outputs 0, state IDLE, pending flag 0, irq_seen flag 0, retry counter 0.
- Bus rule:
  - The sequencer asserts m_bus_en with addr/we/wdata stable until the first edge where m_bus_en && m_bus_ready.
  - Read data is captured on that edge.
  - m_bus_en drops for exactly one cycle before the next transaction starts.
  - Minimum 2 cycles per transaction when ready arrives in the cycle after en.
- Triggers, evaluated in IDLE, only when cfg_enable=1:
  - start_i, or a latched pending request, starts a sequence.
  - cfg_periodic=1 && timer_irq_i=1 && irq_seen=0: tick_o pulses, irq_seen is set, and a sequence starts.
  - irq_seen clears when timer_irq_i=0.
  - A held-high interrupt therefore yields exactly one tick.
  - If start_i and the periodic trigger coincide, only one sequence runs and tick_o still pulses.
- start_i while busy sets pending; pending is serviced immediately after DONE. Multiple requests collapse into one.
- State sequence:
  - IDLE -> RD_HI1 (read MTIME_HI -> h1) -> RD_LO (read MTIME_LO -> l) -> RD_HI2 (read MTIME_HI -> h2).
  - If h2 != h1: increment retry and go to RD_HI1. After MAX_RETRY retries: set err_o, go to IDLE.
  - Otherwise target = {h1,l} + {32'b0, period'}. 64-bit add, carry propagates into the high word, the result wraps modulo 2^64.
  - WR_LO0 (MTIMECMP_LO <= 32'hFFFF_FFFF) -> WR_HI (MTIMECMP_HI <= target[63:32]) -> WR_LO1 (MTIMECMP_LO <= target[31:0]) -> DONE.
  - DONE: done_o pulses for 1 cycle, then go to IDLE.
- busy_o=1 in every state except IDLE.
- Timeout: if ready is absent for TIMEOUT cycles while en=1, deassert en, set err_o, go to IDLE, and drop pending.
- err_o clears on rst or on an accepted start_i.
- cfg_enable deasserted mid-sequence: the current sequence completes so MTIMECMP is never left at 0xFFFFFFFF; no new triggers are accepted.
- cfg_period is sampled at entry to RD_HI1; changes mid-sequence are ignored.
- Reset mid-transaction: m_bus_en=0 on the next edge; no partial-write recovery is attempted.

Test Plan:
- MTIME stub = 0x0000_0000_0000_0100, period 0x10, start_i:
  - Bus reads BFFC, BFF8, BFFC.
  - Bus writes 4000=FFFFFFFF, 4004=00000000, 4000=00000110.
  - done_o pulses once; busy_o low afterwards.
- Rollover: first high read 0, low read 0x00000005, second high read 1:
  - Retry occurs; reads return h=1, l=5 on the next pass.
  - Writes 4004=1, 4000=0x15.
- Carry: MTIME = 0x0000_0000_FFFF_FFF8, period 0x10:
  - Writes 4004=1, 4000=0x8.
  - With period 0, the low write is MTIME+1.
- Periodic: cfg_periodic=1, timer_irq_i held high for 40 cycles:
  - Exactly one tick_o and one sequence.
  - After irq drops and rises again, a second tick and a second sequence.
- Timeout: m_bus_ready held 0:
  - m_bus_en drops after 16 cycles; err_o=1; state IDLE.
  - A subsequent start_i clears err_o.
- start_i issued during WR_HI: a second sequence begins right after done_o. Assert rst during RD_LO: all outputs 0 on the next edge.
